inst_fetch_queue: RTL
=====================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, is the number of queue entries; legal values are powers of two from 2 to 16.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  is the reset: asynchronous, active-low; assertion clears state immediately, deassertion is sampled on clk.
REQ-005 imem_req  output  1  is the instruction-memory request valid.
REQ-006 imem_addr  output  32  is the fetch address; it is held stable while imem_req=1 and imem_addr_ok=0.
REQ-007 imem_addr_ok  input  1  means the memory accepted the request this cycle.
REQ-008 imem_data_ok  input  1  means the memory returns the instruction this cycle; it arrives at least 1 cycle after imem_addr_ok.
REQ-009 imem_rdata  input  32  is the returned instruction word.
REQ-010 out_valid  output  1  means a queue-head entry is presented to decode.
REQ-011 out_ready  input  1  means decode consumes the head when out_valid=1.
REQ-012 out_inst  output  32  is the head instruction.
REQ-013 out_pc  output  32  is the head instruction address.
REQ-014 redirect  input  1  is a branch/exception redirect pulse from downstream.
REQ-015 redirect_pc  input  32  is the new fetch address, valid when redirect=1.

Function
REQ-016 Internal state: fetch PC, FIFO of DEPTH {pc,inst} entries with head/tail pointers and count, one outstanding flag, one discard flag, and the PC of the outstanding request.
REQ-017 At most one request is outstanding, where outstanding means addr_ok has been seen but data_ok has not.
REQ-018 imem_req=1 iff no request is outstanding, or the outstanding request completes with data_ok in this same cycle, and count + outstanding < DEPTH (credit rule; the queue can never overflow).
REQ-019 imem_addr shall equal the fetch PC.
REQ-020 On imem_req and imem_addr_ok: outstanding<=1, outstanding PC<=fetch PC, fetch PC<=fetch PC+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-021 On data_ok with discard=0: push {outstanding PC, imem_rdata} at the tail and set outstanding<=0.
REQ-022 On data_ok with discard=1: drop the data, set outstanding<=0 and discard<=0, and leave the queue unchanged.
REQ-023 out_valid=(count!=0); out_inst and out_pc come from the head entry (registered storage, combinational read).
REQ-024 A pop occurs when out_valid and out_ready; the head advances and count decrements.
REQ-025 A push and a pop in the same cycle leave count unchanged; the pop is legal when full.
REQ-026 Pointers wrap modulo DEPTH.
REQ-027 Redirect has priority over all same-cycle events, with these effects:
- queue flushed: count=0, head=tail, and that cycle's pop and push are ignored;
- fetch PC<=redirect_pc;
- discard<=1 if a request is outstanding and not completing this cycle, or if it is accepted by addr_ok this cycle.
REQ-028 While redirect=1, imem_req is still driven per REQ-018 with the old PC; if addr_ok is seen in that cycle, the request is discarded per REQ-027.
REQ-029 A second redirect while discard=1 keeps discard=1 and replaces the fetch PC.
REQ-030 imem_data_ok while no request is outstanding is ignored.
REQ-031 Best-case latency is 2 cycles: addr_ok at cycle N, data_ok at cycle N+1, out_valid at cycle N+2.

Reset
REQ-032 While rst=0:
- fetch PC=RESET_PC;
- count=0; pointers=0;
- outstanding=0; discard=0;
- imem_req=0; out_valid=0.
REQ-033 imem_req may assert in the first cycle after rst deasserts.
REQ-034 Reset mid-transaction abandons the outstanding request; a late data_ok is ignored per REQ-030.

Verification
REQ-035 Reset release, with addr_ok=1 and data_ok one cycle later, out_ready=1 -> out_pc sequence BFC00000, BFC00004, BFC00008 with matching inst, one per cycle after a 2-cycle fill.
REQ-036 Hold out_ready=0 with fast memory -> exactly 4 entries accepted, imem_req drops to 0 with count=4; raise out_ready -> entries drain in order and fetch resumes.
REQ-037 Assert redirect (redirect_pc=80000180) while one request is outstanding and the queue holds 2 entries -> out_valid=0 next cycle, the outstanding data is dropped, and the first new out_pc is 80000180.
REQ-038 Redirect in the same cycle as a pop and a data_ok push -> count=0 afterwards and no stale entry is ever presented.
REQ-039 Fetch PC set to FFFFFFFC via redirect -> following out_pc values are FFFFFFFC, then 00000000.
REQ-040 Drive rst=0 asynchronously mid-stream, then a stray data_ok -> outputs clear immediately, no entry is pushed, and fetch restarts at BFC00000.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches and buffers {pc,inst} pairs for decode.
// Latency: 2 cycles from imem_addr_ok to out_valid with a single-cycle memory.
// Backpressure: out_ready low fills the queue; a credit check stops fetching before it can overflow.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 4   // power of two, 2..16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_addr_ok,
  input  logic        imem_data_ok,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_outstanding;
  logic          r_discard;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];

  logic          w_complete;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_room;
  logic [CW:0]   w_used;

  // An outstanding request finishing this cycle frees the single request slot.
  assign w_complete = r_outstanding & imem_data_ok;

  // Credit: queued entries plus the in-flight one must leave space for a new fetch.
  assign w_used = {1'b0, r_count} + {{CW{1'b0}}, r_outstanding};
  assign w_room = (w_used < LP_DEPTH);

  // Request is gated by rst so it is low for the whole reset window.
  assign imem_req  = rst & (~r_outstanding | imem_data_ok) & w_room;
  assign imem_addr = r_fetch_pc;
  assign w_fire    = imem_req & imem_addr_ok;

  // Redirect suppresses both push and pop: the whole queue is being thrown away.
  assign w_push    = w_complete & ~r_discard & ~redirect;
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready & ~redirect;

  assign out_pc   = r_pc_mem[r_head];
  assign out_inst = r_inst_mem[r_head];

  // Fetch PC: redirect wins over the sequential +4 advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_fire) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  // Track the single in-flight request and remember its address for the push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outstanding <= 1'b0;
      r_req_pc      <= '0;
    end else if (w_fire) begin
      r_outstanding <= 1'b1;
      r_req_pc      <= r_fetch_pc;
    end else if (w_complete) begin
      r_outstanding <= 1'b0;
    end
  end

  // Discard flag: the in-flight request (old or accepted now) belongs to the stale path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_discard <= 1'b0;
    end else if (redirect) begin
      r_discard <= (r_outstanding & ~imem_data_ok) | w_fire;
    end else if (w_complete) begin
      r_discard <= 1'b0;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Entry storage: plain registers, written at the tail on push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]   <= r_req_pc;
      r_inst_mem[r_tail] <= imem_rdata;
    end
  end

endmodule
